// File: rtl/word_assembler_pkg.sv
// Shared widths, constants and lane-placement helpers for the byte-to-word assembler.
// Byte index k counts bytes in arrival order within a word.
package word_assembler_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned LANES  = 4;
    localparam int unsigned ACC_W  = WORD_W - BYTE_W;

    localparam logic [LANES-1:0] KEEP_FULL = 4'b1111;

    typedef logic [1:0] cnt_t;

    localparam cnt_t CNT_LAST = 2'd3;

    // Bit offset of byte index k inside the output word.
    function automatic logic [4:0] lane_lo(input cnt_t k, input bit msb_first);
        logic [4:0] off;
        off = {k, 3'b000};
        return msb_first ? (5'd24 - off) : off;
    endfunction

    // out_keep bit that covers byte index k (bit3 is always lane [31:24]).
    function automatic cnt_t keep_bit(input cnt_t k, input bit msb_first);
        return msb_first ? ~k : k;
    endfunction

endpackage

// File: rtl/lane_insert.sv
// Places one byte into byte index lane_i of an otherwise-zero word, with the
// matching out_keep bit; all outputs are zero when en_i is low.
module lane_insert
    import word_assembler_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic [1:0]        lane_i,
    input  logic              en_i,
    input  logic [BYTE_W-1:0] data_i,
    output logic [WORD_W-1:0] word_o,
    output logic [LANES-1:0]  keep_o
);

    always_comb begin
        word_o = '0;
        keep_o = '0;
        if (en_i) begin
            word_o[lane_lo(lane_i, MSB_FIRST) +: BYTE_W] = data_i;
            keep_o[keep_bit(lane_i, MSB_FIRST)]          = 1'b1;
        end
    end

endmodule

// File: rtl/word_assembler.sv
// Packs a byte stream into 32-bit words with a per-lane keep mask; in_last flushes
// a partial word. One output register, drained and refilled in the same cycle.
module word_assembler
    import word_assembler_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    output logic [LANES-1:0]  out_keep,
    input  logic              out_ready
);

    cnt_t              cnt_q, cnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              out_valid_q, out_valid_d;
    logic [WORD_W-1:0] out_data_q, out_data_d;
    logic [LANES-1:0]  out_keep_q, out_keep_d;

    logic              completes;
    logic              accept;
    logic              flush;

    logic [LANES-1:0][BYTE_W-1:0] lane_byte;
    logic [LANES-1:0]             lane_en;
    logic [LANES-1:0][WORD_W-1:0] lane_word;
    logic [LANES-1:0][LANES-1:0]  lane_keep;
    logic [WORD_W-1:0]            flush_word;
    logic [LANES-1:0]             flush_keep;

    // Accumulator holds bytes in arrival order (byte k at bits [8k+7:8k]);
    // lane placement for the selected byte order happens only at flush time.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        localparam cnt_t K = cnt_t'(k);

        if (k < LANES - 1) begin : g_acc
            assign lane_byte[k] = (cnt_q == K) ? in_data : acc_q[k*BYTE_W +: BYTE_W];
        end else begin : g_top
            assign lane_byte[k] = in_data;
        end

        assign lane_en[k] = (K <= cnt_q);

        lane_insert #(
            .MSB_FIRST(MSB_FIRST)
        ) u_lane_insert (
            .lane_i(K),
            .en_i  (lane_en[k]),
            .data_i(lane_byte[k]),
            .word_o(lane_word[k]),
            .keep_o(lane_keep[k])
        );
    end

    always_comb begin
        flush_word = '0;
        flush_keep = '0;
        for (int k = 0; k < LANES; k++) begin
            flush_word = flush_word | lane_word[k];
            flush_keep = flush_keep | lane_keep[k];
        end
    end

    // Only a word-completing byte can be stalled, and only by an undrained output.
    always_comb begin
        completes = (cnt_q == CNT_LAST) || (in_valid && in_last);
        in_ready  = !(completes && out_valid_q && !out_ready);
        accept    = in_valid && in_ready;
        flush     = accept && completes;
    end

    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (flush) begin
            cnt_d       = '0;
            acc_d       = '0;
            out_valid_d = 1'b1;
            out_data_d  = flush_word;
            out_keep_d  = flush_keep;
        end else if (accept) begin
            cnt_d = cnt_q + 2'd1;
            acc_d = acc_q | (ACC_W'(in_data) << {cnt_q, 3'b000});
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_keep  = out_keep_q;

endmodule

// File: tb/tb_word_assembler.sv
// Directed bench: both byte orders driven from one stimulus stream, expected words
// hand-computed for each order.
module tb_word_assembler;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        out_ready;

    logic        in_ready_m, out_valid_m;
    logic [31:0] out_data_m;
    logic [3:0]  out_keep_m;
    logic        in_ready_l, out_valid_l;
    logic [31:0] out_data_l;
    logic [3:0]  out_keep_l;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    word_assembler #(
        .MSB_FIRST(1'b1)
    ) u_dut_msb (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_ready (in_ready_m),
        .out_valid(out_valid_m),
        .out_data (out_data_m),
        .out_keep (out_keep_m),
        .out_ready(out_ready)
    );

    word_assembler #(
        .MSB_FIRST(1'b0)
    ) u_dut_lsb (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_ready (in_ready_l),
        .out_valid(out_valid_l),
        .out_data (out_data_l),
        .out_keep (out_keep_l),
        .out_ready(out_ready)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic valid,
                             input logic [31:0] data_m, input logic [3:0] keep_m,
                             input logic [31:0] data_l, input logic [3:0] keep_l);
        check_eq({tag, ".valid_m"}, 32'(out_valid_m), 32'(valid));
        check_eq({tag, ".valid_l"}, 32'(out_valid_l), 32'(valid));
        check_eq({tag, ".data_m"}, out_data_m, data_m);
        check_eq({tag, ".keep_m"}, 32'(out_keep_m), 32'(keep_m));
        check_eq({tag, ".data_l"}, out_data_l, data_l);
        check_eq({tag, ".keep_l"}, 32'(out_keep_l), 32'(keep_l));
    endtask

    task automatic check_ready(input string tag, input logic exp);
        check_eq({tag, ".ready_m"}, 32'(in_ready_m), 32'(exp));
        check_eq({tag, ".ready_l"}, 32'(in_ready_l), 32'(exp));
    endtask

    // Offers one byte for exactly one cycle; in_ready is expected high.
    task automatic send_byte(input logic [7:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(negedge clk);
        check_ready("send", 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 1'b0, 32'h0, 4'h0, 32'h0, 4'h0);
        reset = 1'b0;
        #1;
        check_ready("post_reset", 1'b1);

        // Full word, both byte orders.
        out_ready = 1'b1;
        send_byte(8'hDE, 1'b0);
        send_byte(8'hAD, 1'b0);
        send_byte(8'hBE, 1'b0);
        check_eq("no_early_word", 32'(out_valid_m), 32'(0));
        send_byte(8'hEF, 1'b0);
        check_out("full", 1'b1, 32'hDEADBEEF, 4'hF, 32'hEFBEADDE, 4'hF);
        idle_cycle();
        check_eq("drain_m", 32'(out_valid_m), 32'(0));
        check_eq("drain_l", 32'(out_valid_l), 32'(0));

        // Partial word flushed by in_last.
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b1);
        check_out("partial", 1'b1, 32'h12340000, 4'hC, 32'h00003412, 4'h3);
        idle_cycle();

        // Back-to-back, also proves the count restarted at lane 0.
        send_byte(8'h11, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h13, 1'b0);
        send_byte(8'h14, 1'b0);
        check_out("b2b_w0", 1'b1, 32'h11121314, 4'hF, 32'h14131211, 4'hF);
        send_byte(8'h15, 1'b0);
        send_byte(8'h16, 1'b0);
        send_byte(8'h17, 1'b0);
        send_byte(8'h18, 1'b0);
        check_out("b2b_w1", 1'b1, 32'h15161718, 4'hF, 32'h18171615, 4'hF);
        idle_cycle();

        // Backpressure: pending word, three more bytes go in, fourth stalls.
        out_ready = 1'b0;
        send_byte(8'hA0, 1'b0);
        send_byte(8'hA1, 1'b0);
        send_byte(8'hA2, 1'b0);
        send_byte(8'hA3, 1'b0);
        check_out("bp_first", 1'b1, 32'hA0A1A2A3, 4'hF, 32'hA3A2A1A0, 4'hF);
        send_byte(8'hB0, 1'b0);
        send_byte(8'hB1, 1'b0);
        send_byte(8'hB2, 1'b0);
        check_out("bp_hold", 1'b1, 32'hA0A1A2A3, 4'hF, 32'hA3A2A1A0, 4'hF);
        in_valid = 1'b1;
        in_data  = 8'hB3;
        repeat (2) begin
            @(negedge clk);
            check_ready("bp_stall", 1'b0);
            @(posedge clk);
            #1;
            check_out("bp_stable", 1'b1, 32'hA0A1A2A3, 4'hF, 32'hA3A2A1A0, 4'hF);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_ready("bp_release", 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_out("bp_second", 1'b1, 32'hB0B1B2B3, 4'hF, 32'hB3B2B1B0, 4'hF);
        idle_cycle();
        check_eq("bp_drain", 32'(out_valid_m), 32'(0));

        // Reset with a pending word and a half-built one.
        out_ready = 1'b0;
        send_byte(8'hC0, 1'b0);
        send_byte(8'hC1, 1'b0);
        send_byte(8'hC2, 1'b0);
        send_byte(8'hC3, 1'b0);
        send_byte(8'hD0, 1'b0);
        send_byte(8'hD1, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_out("rst_mid", 1'b0, 32'h0, 4'h0, 32'h0, 4'h0);
        reset = 1'b0;
        #1;
        check_ready("rst_ready", 1'b1);
        out_ready = 1'b1;
        send_byte(8'h21, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h23, 1'b0);
        check_eq("rst_no_word", 32'(out_valid_m), 32'(0));
        send_byte(8'h24, 1'b0);
        check_out("rst_after", 1'b1, 32'h21222324, 4'hF, 32'h24232221, 4'hF);
        idle_cycle();
        check_eq("rst_single_m", 32'(out_valid_m), 32'(0));
        check_eq("rst_single_l", 32'(out_valid_l), 32'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
